func_unit_seq: RTL and testbench
================================

Name: func_unit_seq

Overview:
Multi-cycle function unit sitting directly downstream of the register file. It consumes the A/B operand buses (register-file AD/BD) and produces the result word F, which feeds back to the register-file write data DD. It also produces status flags V, C, N, Z. Single-cycle ALU/shift ops complete in one clock; unsigned multiply is an iterative shift-add sequence under a START/BUSY/DONE handshake.

Parameters:
WIDTH, 16, operand/result width. Iteration count for multi-cycle ops equals WIDTH.

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous, active-low reset
START  input  1  request; sampled only when not BUSY
FS  input  4  function select, sampled with START
A  input  WIDTH  operand A (register-file AD)
B  input  WIDTH  operand B (register-file BD)
F  output  WIDTH  result, low word; feeds register-file DD
HI  output  WIDTH  high word of multiply / remainder of divide; 0 for other ops
V  output  1  overflow
C  output  1  carry
N  output  1  negative
Z  output  1  zero
BUSY  output  1  multi-cycle op in progress
DONE  output  1  one-cycle pulse: F/HI/flags valid and updated

Behaviour:
- Reset (RESET=0, asynchronous): F=0, HI=0, V=C=N=Z=0, BUSY=0, DONE=0, state IDLE, iteration counter 0. A reset during an iteration aborts it; no DONE is produced.
- States: IDLE, ITER. DONE is a registered pulse, not a state.
- FS encodings (mod 2^WIDTH):
  - 0000 F=A
  - 0001 A+1
  - 0010 A+B
  - 0011 A+B+1
  - 0100 A+~B
  - 0101 A+~B+1 (A-B)
  - 0110 A-1
  - 0111 F=A (DIV when FU_DIV_EN)
  - 1000 A&B
  - 1001 A|B
  - 1010 A^B
  - 1011 ~A
  - 1100 F=B
  - 1101 B>>1 logical
  - 1110 B<<1
  - 1111 MUL, unsigned, {HI,F}=A*B
- Single-cycle op: START=1 at edge k in IDLE:
  - F, HI(=0) and flags are registered at edge k.
  - DONE=1 for the cycle after edge k.
  - BUSY stays 0.
- Multi-cycle op: START=1 with FS=1111 at edge k:
  - Edge k latches A and B, sets BUSY=1, loads counter=WIDTH, and enters ITER.
  - Each following edge performs one shift-add step and decrements the counter.
  - At edge k+WIDTH: F/HI/flags are updated, BUSY=0, DONE=1 for one cycle, state IDLE.
  - Latency from START to DONE is WIDTH+1 edges.
- F/HI/flags hold their last values between ops. During ITER they hold the previous result, and internal accumulators are separate.
- START while BUSY=1 is ignored; operands and FS are not re-sampled.
- START during the DONE cycle (state IDLE) is accepted, so back-to-back ops are allowed.
- Flags:
  - N=F[WIDTH-1]; Z=(F==0).
  - Arithmetic ops (0001-0110): C=carry-out of bit WIDTH; V=two's-complement overflow.
  - Logic ops and 0000/1100: C=0, V=0.
  - 1101: C=B[0]. 1110: C=B[WIDTH-1]. V=0 for both.
  - MUL: N=HI[WIDTH-1]; Z=({HI,F}==0); C=V=(HI!=0).

Optional Feature:
Macro FU_DIV_EN.
- Defined: FS=0111 is unsigned restoring divide with F=A/B and HI=A%B. It uses the same ITER timing as MUL (DONE at edge k+WIDTH).
  - Flags: Z=(F==0), N=F[WIDTH-1], C=0, V=0.
  - B==0: F=all-ones, HI=A, V=1, same latency.
- Undefined: FS=0111 is the single-cycle pass-through F=A with C=V=0, and no divider logic is present.

Test Plan:
- Reset: drive RESET=0 mid-MUL (cycle 5) -> F=0, HI=0, flags 0, BUSY=0, and no DONE after release.
- Add: A=16'h7FFF, B=16'h0001, FS=0010, START -> next cycle DONE=1, F=16'h8000, V=1, N=1, C=0, Z=0.
- Subtract: A=16'h0005, B=16'h0005, FS=0101 -> F=0, Z=1, C=1, V=0. Then B>>1 with B=16'h0003, FS=1101 -> F=16'h0001, C=1.
- Multiply: A=16'h1234, B=16'h0100, FS=1111 -> BUSY high 16 cycles, DONE at edge k+16, HI=16'h0012, F=16'h3400, C=V=1. A START pulsed mid-op is ignored.
- Back-to-back: START held across the DONE cycle with FS=0001, A=16'hFFFF -> second DONE one cycle later, F=0, Z=1, C=1.
- FU_DIV_EN: A=100, B=7, FS=0111 -> DONE at edge k+16, F=14, HI=2. With B=0 -> F=16'hFFFF, HI=100, V=1.

Source files
------------

// File: rtl/func_unit_seq.sv
// func_unit_seq: single-cycle ALU/shift ops plus iterative shift-add MUL.
// Define FU_DIV_EN to turn FS=0111 into an iterative restoring divide.
module func_unit_seq #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [3:0]       FS,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] F,
  output logic [WIDTH-1:0] HI,
  output logic             V,
  output logic             C,
  output logic             N,
  output logic             Z,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, ITER} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [WIDTH-1:0] ah_q, ah_d;
  logic [WIDTH-1:0] al_q, al_d;
  logic [WIDTH-1:0] f_d, hi_d;
  logic             v_d, c_d, n_d, z_d;
  logic             done_d;
  logic             start_mc;

  logic [WIDTH-1:0] y;
  logic             cin;
  logic             arith;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_f;
  logic             alu_c;
  logic             alu_v;

  logic [WIDTH:0]   madd;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  logic [WIDTH-1:0] step_hi, step_lo;

  always_comb begin
    y     = '0;
    cin   = 1'b0;
    arith = 1'b0;
    alu_f = A;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (FS)
      4'h1: begin cin = 1'b1; arith = 1'b1; end
      4'h2: begin y = B; arith = 1'b1; end
      4'h3: begin y = B; cin = 1'b1; arith = 1'b1; end
      4'h4: begin y = ~B; arith = 1'b1; end
      4'h5: begin y = ~B; cin = 1'b1; arith = 1'b1; end
      4'h6: begin y = '1; arith = 1'b1; end
      4'h8: alu_f = A & B;
      4'h9: alu_f = A | B;
      4'hA: alu_f = A ^ B;
      4'hB: alu_f = ~A;
      4'hC: alu_f = B;
      4'hD: begin
        alu_f = {1'b0, B[WIDTH-1:1]};
        alu_c = B[0];
      end
      4'hE: begin
        alu_f = {B[WIDTH-2:0], 1'b0};
        alu_c = B[WIDTH-1];
      end
      default: alu_f = A;
    endcase
    sum = {1'b0, A} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    if (arith) begin
      alu_f = sum[WIDTH-1:0];
      alu_c = sum[WIDTH];
      alu_v = (A[WIDTH-1] == y[WIDTH-1]) &&
              (sum[WIDTH-1] != A[WIDTH-1]);
    end
  end

  // {ah,al} shifts right; multiplier bits leave al as product bits enter
  assign madd   = {1'b0, ah_q} + (al_q[0] ? {1'b0, op_q} : '0);
  assign mul_hi = madd[WIDTH:1];
  assign mul_lo = {madd[0], al_q[WIDTH-1:1]};

`ifdef FU_DIV_EN
  logic             div_q, div_d;
  logic             is_div;
  logic [WIDTH:0]   rsh;
  logic             ge;
  logic [WIDTH-1:0] rdif;
  logic [WIDTH-1:0] div_hi, div_lo;

  assign is_div   = (FS == 4'h7);
  assign start_mc = (FS == 4'hF) || is_div;
  // ah holds the partial remainder, al the dividend/quotient
  assign rsh      = {ah_q, al_q[WIDTH-1]};
  assign ge       = (rsh >= {1'b0, op_q});
  assign rdif     = rsh[WIDTH-1:0] - op_q;
  assign div_hi   = ge ? rdif : rsh[WIDTH-1:0];
  assign div_lo   = {al_q[WIDTH-2:0], ge};
  assign step_hi  = div_q ? div_hi : mul_hi;
  assign step_lo  = div_q ? div_lo : mul_lo;
`else
  assign start_mc = (FS == 4'hF);
  assign step_hi  = mul_hi;
  assign step_lo  = mul_lo;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ah_d    = ah_q;
    al_d    = al_q;
    f_d     = F;
    hi_d    = HI;
    v_d     = V;
    c_d     = C;
    n_d     = N;
    z_d     = Z;
    done_d  = 1'b0;
`ifdef FU_DIV_EN
    div_d   = div_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (START) begin
          if (start_mc) begin
            state_d = ITER;
            cnt_d   = CW'(WIDTH);
            ah_d    = '0;
            op_d    = A;
            al_d    = B;
`ifdef FU_DIV_EN
            div_d   = is_div;
            if (is_div) begin
              op_d = B;
              al_d = A;
            end
`endif
          end else begin
            f_d    = alu_f;
            hi_d   = '0;
            v_d    = alu_v;
            c_d    = alu_c;
            n_d    = alu_f[WIDTH-1];
            z_d    = (alu_f == '0);
            done_d = 1'b1;
          end
        end
      end
      ITER: begin
        ah_d  = step_hi;
        al_d  = step_lo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          f_d     = step_lo;
          hi_d    = step_hi;
          n_d     = step_hi[WIDTH-1];
          z_d     = ({step_hi, step_lo} == '0);
          c_d     = (step_hi != '0);
          v_d     = (step_hi != '0);
`ifdef FU_DIV_EN
          if (div_q) begin
            n_d = step_lo[WIDTH-1];
            z_d = (step_lo == '0);
            c_d = 1'b0;
            v_d = (op_q == '0);
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      ah_q    <= '0;
      al_q    <= '0;
      F       <= '0;
      HI      <= '0;
      V       <= 1'b0;
      C       <= 1'b0;
      N       <= 1'b0;
      Z       <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      ah_q    <= ah_d;
      al_q    <= al_d;
      F       <= f_d;
      HI      <= hi_d;
      V       <= v_d;
      C       <= c_d;
      N       <= n_d;
      Z       <= z_d;
      DONE    <= done_d;
    end
  end

`ifdef FU_DIV_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) div_q <= 1'b0;
    else        div_q <= div_d;
  end
`endif

  assign BUSY = (state_q == ITER);

endmodule

// File: tb/tb_func_unit_seq.sv
// Randomized bench for func_unit_seq against an arithmetic reference model.
// Directed cases cover add/sub/shift/mul/back-to-back/reset and divide.
module tb_func_unit_seq;

  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         START;
  logic [3:0]   FS;
  logic [W-1:0] A, B;
  logic [W-1:0] F, HI;
  logic         V, C, N, Z, BUSY, DONE;

  int checks = 0;
  int failures = 0;

  func_unit_seq #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .FS(FS),
    .A(A), .B(B), .F(F), .HI(HI),
    .V(V), .C(C), .N(N), .Z(Z),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model(
    input  logic [3:0]   fs,
    input  logic [W-1:0] a, b,
    output logic [W-1:0] f, hi,
    output logic         v, c, n, z, mc);
    int sa, sb, ua, ub, r, u;
    logic [31:0] p;
    bit ar;
    sa = $signed(a); sb = $signed(b);
    ua = int'(a);    ub = int'(b);
    r = 0; u = 0; ar = 0;
    f = a; hi = '0; v = 0; c = 0; mc = 0;
    case (fs)
      4'h1: begin r = sa + 1;      u = ua + 1;                ar = 1; end
      4'h2: begin r = sa + sb;     u = ua + ub;               ar = 1; end
      4'h3: begin r = sa + sb + 1; u = ua + ub + 1;           ar = 1; end
      4'h4: begin r = sa - sb - 1; u = ua + (65535 - ub);     ar = 1; end
      4'h5: begin r = sa - sb;     u = ua + (65535 - ub) + 1; ar = 1; end
      4'h6: begin r = sa - 1;      u = ua + 65535;            ar = 1; end
      4'h8: f = a & b;
      4'h9: f = a | b;
      4'hA: f = a ^ b;
      4'hB: f = ~a;
      4'hC: f = b;
      4'hD: begin f = b >> 1; c = b[0]; end
      4'hE: begin f = b << 1; c = b[W-1]; end
`ifdef FU_DIV_EN
      4'h7: begin
        mc = 1;
        if (b == 0) begin f = '1; hi = a; v = 1; end
        else begin f = a / b; hi = a % b; end
      end
`endif
      default: f = a;
    endcase
    if (ar) begin
      f = u[W-1:0];
      c = (u > 65535);
      v = (r > 32767) || (r < -32768);
    end
    n = f[W-1];
    z = (f == 0);
    if (fs == 4'hF) begin
      mc = 1;
      p  = {16'h0, a} * {16'h0, b};
      f  = p[15:0];
      hi = p[31:16];
      n  = hi[W-1];
      z  = (p == 0);
      c  = (hi != 0);
      v  = (hi != 0);
    end
  endfunction

  task automatic run_op(input logic [3:0] fs, input logic [W-1:0] a, b);
    logic [W-1:0] ef, eh;
    logic ev, ec, en, ez, mc;
    int n;
    model(fs, a, b, ef, eh, ev, ec, en, ez, mc);
    @(negedge CLK);
    START = 1'b1; FS = fs; A = a; B = b;
    @(posedge CLK); #1;
    START = 1'b0;
    if (mc) begin
      n = 0;
      check("busy_start", BUSY, 1);
      do begin
        A = W'($urandom); B = W'($urandom);
        FS = 4'($urandom); START = 1'($urandom);
        @(posedge CLK); #1;
        n++;
        if (!DONE && n < W) check("busy_iter", BUSY, 1);
      end while (!DONE && n < W + 4);
      START = 1'b0;
      check("latency", n, W);
      check("busy_end", BUSY, 0);
    end else begin
      check("busy_sc", BUSY, 0);
    end
    check("done", DONE, 1);
    check("F", F, ef);
    check("HI", HI, eh);
    check("flags", {V, C, N, Z}, {ev, ec, en, ez});
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    logic [W-1:0] hold;
    bit saw;
    RESET = 1'b0; START = 1'b0; FS = '0; A = '0; B = '0;
    #12;
    check("rst_F", F, 0);
    check("rst_HI", HI, 0);
    check("rst_flags", {V, C, N, Z}, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    @(negedge CLK) RESET = 1'b1;

    run_op(4'h2, 16'h7FFF, 16'h0001);
    check("add_F", F, 16'h8000);
    run_op(4'h5, 16'h0005, 16'h0005);
    check("sub_Z", Z, 1);
    run_op(4'hD, 16'h0000, 16'h0003);
    check("shr_C", C, 1);
    run_op(4'hF, 16'h1234, 16'h0100);
    check("mul_HI", HI, 16'h0012);
    check("mul_F", F, 16'h3400);

    // abort a multiply part-way: outputs clear and no DONE follows
    @(negedge CLK);
    START = 1'b1; FS = 4'hF; A = 16'h00FF; B = 16'h00FF;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (4) @(posedge CLK);
    #2 RESET = 1'b0;
    #1;
    check("abort_F", F, 0);
    check("abort_HI", HI, 0);
    check("abort_flags", {V, C, N, Z}, 0);
    check("abort_busy", BUSY, 0);
    check("abort_done", DONE, 0);
    @(negedge CLK) RESET = 1'b1;
    saw = 0;
    repeat (W + 4) begin
      @(posedge CLK); #1;
      if (DONE || BUSY) saw = 1;
    end
    check("abort_quiet", saw, 0);

    // START held through the DONE cycle issues a second op
    @(negedge CLK);
    START = 1'b1; FS = 4'h1; A = 16'h0010; B = '0;
    @(posedge CLK); #1;
    check("b2b_done1", DONE, 1);
    check("b2b_F1", F, 16'h0011);
    A = 16'hFFFF;
    @(posedge CLK); #1;
    START = 1'b0;
    check("b2b_done2", DONE, 1);
    check("b2b_F2", F, 16'h0000);
    check("b2b_flags", {V, C, N, Z}, 4'b0101);

`ifdef FU_DIV_EN
    run_op(4'h7, 16'd100, 16'd7);
    check("div_F", F, 16'd14);
    check("div_HI", HI, 16'd2);
    run_op(4'h7, 16'd100, 16'd0);
    check("div0_F", F, 16'hFFFF);
    check("div0_V", V, 1);
`endif

    repeat (80) begin
      run_op(4'($urandom), pick(), pick());
      hold = F;
      repeat ($urandom_range(0, 2)) begin
        @(posedge CLK); #1;
        check("idle_done", DONE, 0);
        check("idle_hold", F, hold);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
